// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared width, FSM state and owner encodings for the memory port arbiter
package mem_port_arbiter_pkg;

    localparam int WORD_SIZE = 16;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_counter.sv
// arb_latency_counter: counts down the remaining cycles of a memory access
module arb_latency_counter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam int CW = $clog2(MEM_LATENCY + 1);

    logic [CW-1:0] cnt;

    // reload on every grant, then step down once per access cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= CW'(MEM_LATENCY - 1);
        else if (dec)
            cnt <= cnt - 1'b1;
    end

    assign zero = cnt == '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle memory port between instruction fetch and data access
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE    = mem_port_arbiter_pkg::WORD_SIZE,
    parameter int MEM_LATENCY  = 2,
    parameter int MAX_D_GRANTS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    input  logic                 i_abort,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ready,
    input  logic                 d_rd,
    input  logic                 d_wr,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 if_stall,
    output logic                 mem_stall,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata
);
    localparam int SW = $clog2(MAX_D_GRANTS + 1);

    arb_state_t           state;
    owner_t               owner;
    logic [WORD_SIZE-1:0] addr_q, wdata_q;
    logic                 is_wr;
    logic [SW-1:0]        d_streak;
    logic                 cnt_zero;
    logic                 access, arb, i_cand, d_cand, grant_i, grant_d, grant;

    assign access  = state == ARB_ACCESS;
    assign arb     = !access;
    assign i_ready = state == ARB_RESP && owner == OWN_I;
    assign d_ready = state == ARB_RESP && owner == OWN_D;
    // the requester completing this cycle is still holding its request, so it is masked
    assign i_cand  = arb && i_req && !i_abort && !i_ready;
    assign d_cand  = arb && (d_rd || d_wr) && !d_ready;
    assign grant_i = i_cand && (!d_cand || d_streak == SW'(MAX_D_GRANTS));
    assign grant_d = d_cand && !grant_i;
    assign grant   = grant_i || grant_d;

    assign mem_read  = access && !is_wr;
    assign mem_write = access && is_wr;
    assign mem_addr  = access ? addr_q : '0;
    assign mem_wdata = mem_write ? wdata_q : '0;
    // stalls are held low while the arbiter itself is in reset
    assign if_stall  = reset_n && i_req && !i_ready;
    assign mem_stall = reset_n && (d_rd || d_wr) && !d_ready;

    arb_latency_counter #(.MEM_LATENCY(MEM_LATENCY)) u_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (grant),
        .dec    (access && !cnt_zero),
        .zero   (cnt_zero)
    );

    // access sequencing: grant and latch, run the access, capture read data, respond
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ARB_IDLE;
            owner   <= OWN_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            is_wr   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else if (arb) begin
            state <= grant ? ARB_ACCESS : ARB_IDLE;
            owner <= grant_i ? OWN_I : grant_d ? OWN_D : OWN_NONE;
            if (grant) begin
                addr_q  <= grant_i ? i_addr : d_addr;
                wdata_q <= grant_d ? d_wdata : '0;
                is_wr   <= grant_d && d_wr;
            end
        end else if (owner == OWN_I && i_abort) begin
            state <= ARB_IDLE;
            owner <= OWN_NONE;
        end else if (cnt_zero) begin
            state <= ARB_RESP;
            if (owner == OWN_I)
                i_rdata <= mem_rdata;
            else if (!is_wr)
                d_rdata <= mem_rdata;
        end
    end

    // count data grants made while a fetch waits, so a fetch is forced after MAX_D_GRANTS
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            d_streak <= '0;
        else if (!i_req || grant_i)
            d_streak <= '0;
        else if (grant_d && d_streak != SW'(MAX_D_GRANTS))
            d_streak <= d_streak + 1'b1;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed cycle-by-cycle checks of the memory port arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req, i_abort, d_rd, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_ready, d_ready, if_stall, mem_stall, mem_read, mem_write;
    logic [5:0]  ctrl;
    int          n_pass = 0;
    int          n_total = 0;

    mem_port_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(2), .MAX_D_GRANTS(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_abort(i_abort), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .if_stall(if_stall), .mem_stall(mem_stall), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign ctrl = {mem_read, mem_write, i_ready, d_ready, if_stall, mem_stall};

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            i_req = 0; i_abort = 0; d_rd = 0; d_wr = 0;
        end
    endtask

    task automatic test_reset;
        reset_n = 0; i_req = 0; i_abort = 0; d_rd = 0; d_wr = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({i_rdata, i_ready, d_rdata, d_ready, if_stall, mem_stall, mem_read, mem_write, mem_addr, mem_wdata} !== '0)
            $display("FAIL reset_outputs: got ctrl=%b i_rdata=%h d_rdata=%h want all zero", ctrl, i_rdata, d_rdata);
        else n_pass++;
        reset_n = 1;
    endtask

    task automatic test_fetch;
        logic [5:0] e_ctrl [4] = '{6'b000010, 6'b100010, 6'b100010, 6'b001000};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            i_req = 1; i_addr = 16'h0010; mem_rdata = 16'h6A01;
            #1;
            n_total++;
            if ({ctrl, mem_addr} !== {e_ctrl[c], (c == 1 || c == 2) ? 16'h0010 : 16'h0000})
                $display("FAIL fetch_c%0d: got ctrl=%b addr=%h want ctrl=%b", c, ctrl, mem_addr, e_ctrl[c]);
            else n_pass++;
        end
        n_total++;
        if (i_rdata !== 16'h6A01) $display("FAIL fetch_rdata: got %h want 6a01", i_rdata);
        else n_pass++;
        idle(2);
    endtask

    task automatic test_contention;
        logic [5:0]  e_ctrl [7] = '{6'b000011, 6'b100011, 6'b100011, 6'b000110, 6'b100010, 6'b100010, 6'b001000};
        logic [15:0] e_addr [7] = '{16'h0, 16'h0040, 16'h0040, 16'h0, 16'h0100, 16'h0100, 16'h0};
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            i_req = 1; i_addr = 16'h0100; d_rd = c <= 3; d_addr = 16'h0040;
            mem_rdata = c < 4 ? 16'h1234 : 16'h5678;
            #1;
            n_total++;
            if ({ctrl, mem_addr} !== {e_ctrl[c], e_addr[c]})
                $display("FAIL contention_c%0d: got ctrl=%b addr=%h want ctrl=%b addr=%h", c, ctrl, mem_addr, e_ctrl[c], e_addr[c]);
            else n_pass++;
            if (c == 3) begin
                n_total++;
                if (d_rdata !== 16'h1234) $display("FAIL contention_d_rdata: got %h want 1234", d_rdata);
                else n_pass++;
            end
        end
        n_total++;
        if (i_rdata !== 16'h5678) $display("FAIL contention_i_rdata: got %h want 5678", i_rdata);
        else n_pass++;
        idle(2);
    endtask

    task automatic test_store;
        logic [5:0] e_ctrl [4] = '{6'b000001, 6'b010001, 6'b010001, 6'b000100};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            d_wr = c <= 3; d_addr = 16'h0020; d_wdata = 16'hBEEF; mem_rdata = 16'hDEAD;
            #1;
            if (c < 4) begin
                n_total++;
                if ({ctrl, mem_addr, mem_wdata} !== {e_ctrl[c], (c == 1 || c == 2) ? 32'h0020_BEEF : 32'h0})
                    $display("FAIL store_c%0d: got ctrl=%b addr=%h wdata=%h want ctrl=%b", c, ctrl, mem_addr, mem_wdata, e_ctrl[c]);
                else n_pass++;
            end
            if (c >= 3) begin
                n_total++;
                if (d_rdata !== 16'h1234) $display("FAIL store_d_rdata_c%0d: got %h want 1234", c, d_rdata);
                else n_pass++;
            end
        end
        idle(2);
    endtask

    task automatic test_starvation;
        logic [17:0] e;
        for (int c = 0; c < 23; c++) begin
            @(negedge clk);
            i_req = c <= 19; i_abort = c < 16; i_addr = 16'h0200;
            d_rd = 1; d_addr = 16'h0300; mem_rdata = 16'h0;
            e[17] = c == 19;
            e[16] = (c < 16 && c % 4 == 3) || c == 22;
            e[15:0] = ((c < 16 && (c % 4 == 1 || c % 4 == 2)) || c == 20 || c == 21) ? 16'h0300 :
                      (c == 17 || c == 18) ? 16'h0200 : 16'h0;
            #1;
            n_total++;
            if ({i_ready, d_ready, mem_addr} !== e)
                $display("FAIL starvation_c%0d: got i_ready=%b d_ready=%b addr=%h want %b %b %h",
                         c, i_ready, d_ready, mem_addr, e[17], e[16], e[15:0]);
            else n_pass++;
        end
        idle(2);
    endtask

    task automatic test_abort;
        logic [16:0] e;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            i_req = c <= 1 || c >= 6; i_abort = c == 1;
            i_addr = c < 6 ? 16'h0050 : 16'h0060; mem_rdata = 16'h7777;
            e[16] = c == 9;
            e[15:0] = c == 1 ? 16'h0050 : (c == 7 || c == 8) ? 16'h0060 : 16'h0;
            #1;
            n_total++;
            if ({i_ready, mem_read, mem_addr} !== {e[16], e[15:0] != 16'h0, e[15:0]})
                $display("FAIL abort_c%0d: got i_ready=%b mem_read=%b addr=%h want %b %h", c, i_ready, mem_read, mem_addr, e[16], e[15:0]);
            else n_pass++;
        end
        n_total++;
        if (i_rdata !== 16'h7777) $display("FAIL abort_refetch_rdata: got %h want 7777", i_rdata);
        else n_pass++;
        idle(2);
    endtask

    task automatic test_reset_mid;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            d_wr = 1; d_addr = 16'h0070; d_wdata = 16'h1111;
            #1;
        end
        n_total++;
        if ({mem_write, mem_addr, mem_wdata} !== {1'b1, 16'h0070, 16'h1111})
            $display("FAIL reset_mid_pre: got mem_write=%b addr=%h wdata=%h want 1 0070 1111", mem_write, mem_addr, mem_wdata);
        else n_pass++;
        #2;
        reset_n = 0; d_wr = 0;
        #1;
        n_total++;
        if ({i_rdata, i_ready, d_rdata, d_ready, if_stall, mem_stall, mem_read, mem_write, mem_addr, mem_wdata} !== '0)
            $display("FAIL reset_mid_outputs: got ctrl=%b d_rdata=%h i_rdata=%h want all zero", ctrl, d_rdata, i_rdata);
        else n_pass++;
        @(negedge clk);
        reset_n = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            n_total++;
            if ({ctrl, mem_addr} !== '0)
                $display("FAIL reset_mid_after_c%0d: got ctrl=%b addr=%h want 0", c, ctrl, mem_addr);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_contention;
        test_store;
        test_starvation;
        test_abort;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
